npc_ctrl_fsm: RTL and testbench

Multi-cycle control sequencer for the NPC core. It fetches an instruction through a valid/ready IFU interface, holds it for the decoder, and drives the LSU for loads and stores. It then commits exactly one write-back per instruction by generating rf_wen, wb_sel, pc_wen and csr_wen. It sits between IFU, LSU, the register file and the PC register, and replaces single-cycle write-back timing.

---
 rtl/npc_ctrl_fsm.sv | 190 +++++++++++++++++++
 tb/tb_npc_ctrl_fsm.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/npc_ctrl_fsm.sv
// Multi-cycle NPC control sequencer: fetch over IFU valid/ready, optional LSU access,
// then exactly one write-back commit (rf_wen/wb_sel/csr_wen/pc_wen) per instruction.
module npc_ctrl_fsm #(
    parameter int unsigned TIMEOUT_CYC = 255,
    parameter int unsigned XLEN        = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            ifu_req_valid,
    input  logic            ifu_req_ready,
    input  logic            ifu_rsp_valid,
    output logic            ifu_rsp_ready,
    input  logic [XLEN-1:0] ifu_rdata,
    output logic [XLEN-1:0] inst,
    output logic            lsu_req_valid,
    input  logic            lsu_req_ready,
    output logic            lsu_we,
    input  logic            lsu_rsp_valid,
    output logic            rf_wen,
    output logic [2:0]      wb_sel,
    output logic            csr_wen,
    output logic            pc_wen,
    output logic            err
);

    localparam int unsigned CW = $clog2(TIMEOUT_CYC + 1);

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_OPIMM  = 7'b0010011;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    localparam logic [2:0] WB_MEM  = 3'b000;
    localparam logic [2:0] WB_PC4  = 3'b001;
    localparam logic [2:0] WB_ALU  = 3'b010;
    localparam logic [2:0] WB_IMM  = 3'b011;
    localparam logic [2:0] WB_CSR  = 3'b100;
    localparam logic [2:0] WB_NONE = 3'b111;

    typedef enum logic [2:0] {
        S_FETCH,
        S_WAIT_INST,
        S_EXEC,
        S_MEM_REQ,
        S_MEM_WAIT,
        S_WB,
        S_ERROR
    } state_t;

    state_t          r_state;
    logic [CW-1:0]   r_cnt;
    logic [XLEN-1:0] r_inst;
    logic            r_ifu_req_valid;
    logic            r_ifu_rsp_ready;
    logic            r_lsu_req_valid;
    logic            r_lsu_we;
    logic            r_rf_wen;
    logic [2:0]      r_wb_sel;
    logic            r_csr_wen;
    logic            r_pc_wen;
    logic            r_err;

    state_t          w_next;
    logic            w_wait;
    logic            w_hs;
    logic            w_timeout;
    logic [CW-1:0]   w_cnt_inc;
    logic [6:0]      w_op;
    logic            w_rf_wen;
    logic [2:0]      w_wb_sel;
    logic            w_csr_wen;
    logic            w_is_wb;

    // Next-state decode; a handshake in the timeout cycle takes priority over the timeout.
    always_comb begin
        w_next    = r_state;
        w_wait    = 1'b0;
        w_hs      = 1'b0;
        w_op      = r_inst[6:0];
        w_cnt_inc = r_cnt + CW'(1);
        case (r_state)
            S_FETCH: begin
                // The cycle right after reset has no request raised yet, so it neither waits nor handshakes.
                w_wait = r_ifu_req_valid;
                w_hs   = r_ifu_req_valid && ifu_req_ready;
                if (w_hs) w_next = S_WAIT_INST;
            end
            S_WAIT_INST: begin
                w_wait = 1'b1;
                w_hs   = ifu_rsp_valid;
                if (w_hs) w_next = S_EXEC;
            end
            S_EXEC: begin
                case (w_op)
                    OP_LOAD, OP_STORE: w_next = S_MEM_REQ;
                    OP_AUIPC, OP_OPIMM, OP_OP, OP_LUI,
                    OP_JAL, OP_JALR, OP_BRANCH, OP_SYSTEM: w_next = S_WB;
                    default: w_next = S_ERROR;
                endcase
            end
            S_MEM_REQ: begin
                w_wait = 1'b1;
                w_hs   = lsu_req_ready;
                if (w_hs) w_next = S_MEM_WAIT;
            end
            S_MEM_WAIT: begin
                w_wait = 1'b1;
                w_hs   = lsu_rsp_valid;
                if (w_hs) w_next = S_WB;
            end
            S_WB:    w_next = S_FETCH;
            S_ERROR: w_next = S_ERROR;
            default: w_next = S_ERROR;
        endcase
        w_timeout = w_wait && !w_hs && (w_cnt_inc == CW'(TIMEOUT_CYC));
        if (w_timeout) w_next = S_ERROR;
    end

    // Write-back source selection from the latched opcode.
    always_comb begin
        w_rf_wen  = 1'b0;
        w_wb_sel  = WB_NONE;
        w_csr_wen = 1'b0;
        case (w_op)
            OP_AUIPC, OP_OPIMM, OP_OP: begin w_rf_wen = 1'b1; w_wb_sel = WB_ALU; end
            OP_LUI:                    begin w_rf_wen = 1'b1; w_wb_sel = WB_IMM; end
            OP_JAL, OP_JALR:           begin w_rf_wen = 1'b1; w_wb_sel = WB_PC4; end
            OP_LOAD:                   begin w_rf_wen = 1'b1; w_wb_sel = WB_MEM; end
            OP_SYSTEM: begin
                w_rf_wen  = 1'b1;
                w_wb_sel  = WB_CSR;
                w_csr_wen = 1'b1;
            end
            default: ;
        endcase
        w_is_wb = (w_next == S_WB);
    end

    // State, counter and outputs all registered from the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state         <= S_FETCH;
            r_cnt           <= '0;
            r_inst          <= '0;
            r_ifu_req_valid <= 1'b0;
            r_ifu_rsp_ready <= 1'b0;
            r_lsu_req_valid <= 1'b0;
            r_lsu_we        <= 1'b0;
            r_rf_wen        <= 1'b0;
            r_wb_sel        <= WB_NONE;
            r_csr_wen       <= 1'b0;
            r_pc_wen        <= 1'b0;
            r_err           <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_next != r_state) r_cnt <= '0;
            else if (w_wait)       r_cnt <= w_cnt_inc;
            if (r_state == S_WAIT_INST && ifu_rsp_valid) begin
                r_inst   <= ifu_rdata;
                r_lsu_we <= (ifu_rdata[6:0] == OP_STORE);
            end
            r_ifu_req_valid <= (w_next == S_FETCH);
            r_ifu_rsp_ready <= (w_next == S_WAIT_INST);
            r_lsu_req_valid <= (w_next == S_MEM_REQ);
            r_rf_wen        <= w_is_wb && w_rf_wen;
            r_wb_sel        <= w_is_wb ? w_wb_sel : WB_NONE;
            r_csr_wen       <= w_is_wb && w_csr_wen;
            r_pc_wen        <= w_is_wb;
            r_err           <= r_err || (w_next == S_ERROR);
        end
    end

    assign ifu_req_valid = r_ifu_req_valid;
    assign ifu_rsp_ready = r_ifu_rsp_ready;
    assign inst          = r_inst;
    assign lsu_req_valid = r_lsu_req_valid;
    assign lsu_we        = r_lsu_we;
    assign rf_wen        = r_rf_wen;
    assign wb_sel        = r_wb_sel;
    assign csr_wen       = r_csr_wen;
    assign pc_wen        = r_pc_wen;
    assign err           = r_err;

endmodule

// File: tb/tb_npc_ctrl_fsm.sv
// Bench for npc_ctrl_fsm: directed vector table, reset corner cases and random
// instructions/delays checked against a per-instruction latency/outcome model.
module tb_npc_ctrl_fsm;

    localparam int T = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ifu_req_valid, ifu_req_ready, ifu_rsp_valid, ifu_rsp_ready;
    logic [31:0] ifu_rdata, inst;
    logic        lsu_req_valid, lsu_req_ready, lsu_we, lsu_rsp_valid;
    logic        rf_wen, csr_wen, pc_wen, err;
    logic [2:0]  wb_sel;

    npc_ctrl_fsm #(.TIMEOUT_CYC(T), .XLEN(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready),
        .ifu_rsp_valid(ifu_rsp_valid), .ifu_rsp_ready(ifu_rsp_ready),
        .ifu_rdata(ifu_rdata), .inst(inst),
        .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready),
        .lsu_we(lsu_we), .lsu_rsp_valid(lsu_rsp_valid),
        .rf_wen(rf_wen), .wb_sel(wb_sel), .csr_wen(csr_wen),
        .pc_wen(pc_wen), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rf;
        logic [2:0] sel;
        logic       csr;
        logic       we;
        int         lreq;
        int         lat;
        logic       err;
    } res_t;

    typedef struct {
        logic [31:0] ins;
        int          d1, d2, d3, d4;
        res_t        exp;
    } vec_t;

    int pass_cnt = 0;
    int total    = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        ifu_req_ready = 1'b0;
        ifu_rsp_valid = 1'b0;
        lsu_req_ready = 1'b0;
        lsu_rsp_valid = 1'b0;
        ifu_rdata     = '0;
    endtask

    // Leaves the bench in the first FETCH cycle after release.
    task automatic do_reset();
        idle_inputs();
        rst_n = 1'b0;
        step();
        step();
        chk("rst_ifu_req_valid", 32'(ifu_req_valid), 32'd0);
        chk("rst_strobes", 32'({lsu_req_valid, rf_wen, csr_wen, pc_wen, ifu_rsp_ready}), 32'd0);
        chk("rst_wb_sel", 32'(wb_sel), 32'd7);
        chk("rst_err_inst", {inst[30:0], err}, 32'd0);
        rst_n = 1'b1;
        step();
        chk("first_fetch_valid", 32'(ifu_req_valid), 32'd1);
    endtask

    // Reference model: what one instruction should produce, from the opcode and the wait counts.
    function automatic res_t model(input logic [31:0] ins, input int d1, d2, d3, d4);
        res_t x;
        int t;
        logic [6:0] op;
        logic mem, legal;
        x = '{rf: 1'b0, sel: 3'b111, csr: 1'b0, we: 1'b0, lreq: 0, lat: 0, err: 1'b0};
        op    = ins[6:0];
        mem   = (op == 7'b0000011) || (op == 7'b0100011);
        legal = mem || (op inside {7'b0010111, 7'b0010011, 7'b0110011, 7'b0110111,
                                   7'b1101111, 7'b1100111, 7'b1100011, 7'b1110011});
        x.we  = (op == 7'b0100011);
        t = 0;
        if (d1 >= T) begin x.err = 1'b1; x.lat = t + T + 1; return x; end
        t += d1 + 1;
        if (d2 >= T) begin x.err = 1'b1; x.lat = t + T + 1; return x; end
        t += d2 + 1;
        t += 1;
        if (!legal) begin x.err = 1'b1; x.lat = t + 1; return x; end
        if (mem) begin
            if (d3 >= T) begin x.lreq = T; x.err = 1'b1; x.lat = t + T + 1; return x; end
            x.lreq = d3 + 1;
            t += d3 + 1;
            if (d4 >= T) begin x.err = 1'b1; x.lat = t + T + 1; return x; end
            t += d4 + 1;
        end
        x.lat = t + 1;
        case (op)
            7'b0010111, 7'b0010011, 7'b0110011: begin x.rf = 1'b1; x.sel = 3'b010; end
            7'b0110111:             begin x.rf = 1'b1; x.sel = 3'b011; end
            7'b1101111, 7'b1100111: begin x.rf = 1'b1; x.sel = 3'b001; end
            7'b0000011:             begin x.rf = 1'b1; x.sel = 3'b000; end
            7'b1110011:             begin x.rf = 1'b1; x.sel = 3'b100; x.csr = 1'b1; end
            default: ;
        endcase
        return x;
    endfunction

    // Plays IFU and LSU with the requested wait counts and noise on idle inputs,
    // stopping at the commit cycle (pc_wen) or the error cycle.
    task automatic run_inst(input logic [31:0] ins, input int d1, d2, d3, d4,
                            output res_t r, output logic pw, output logic early,
                            output logic [31:0] inst_seen);
        int s1, s2, s3, s4;
        logic mw, mw_go;
        s1 = 0; s2 = 0; s3 = 0; s4 = 0; mw = 1'b0;
        r = '{rf: 1'b0, sel: 3'b111, csr: 1'b0, we: 1'b0, lreq: 0, lat: 0, err: 1'b0};
        pw = 1'b0; early = 1'b0; inst_seen = '0;
        for (int c = 1; c <= 200; c++) begin
            r.lat = c;
            if (pc_wen || err) begin
                r.rf = rf_wen; r.sel = wb_sel; r.csr = csr_wen; r.err = err;
                pw = pc_wen; inst_seen = inst;
                break;
            end
            if (rf_wen || csr_wen) early = 1'b1;
            idle_inputs();
            ifu_rdata = $urandom;
            mw_go = 1'b0;
            if (ifu_req_valid) begin
                ifu_req_ready = (s1 == d1);
                s1++;
                ifu_rsp_valid = 1'($urandom);
                lsu_rsp_valid = 1'($urandom);
            end
            if (ifu_rsp_ready) begin
                ifu_rsp_valid = (s2 == d2);
                if (ifu_rsp_valid) ifu_rdata = ins;
                s2++;
                lsu_req_ready = 1'($urandom);
            end
            if (lsu_req_valid) begin
                r.we = lsu_we;
                r.lreq++;
                lsu_req_ready = (s3 == d3);
                mw_go = lsu_req_ready;
                s3++;
            end else if (mw) begin
                lsu_rsp_valid = (s4 == d4);
                s4++;
                ifu_rsp_valid = 1'($urandom);
            end
            if (mw_go) mw = 1'b1;
            step();
        end
    endtask

    task automatic err_hold();
        for (int i = 0; i < 4; i++) begin
            ifu_req_ready = 1'($urandom);
            ifu_rsp_valid = 1'($urandom);
            lsu_req_ready = 1'($urandom);
            lsu_rsp_valid = 1'($urandom);
            step();
            chk("err_sticky", 32'(err), 32'd1);
            chk("err_quiet", 32'({ifu_req_valid, ifu_rsp_ready, lsu_req_valid, rf_wen, csr_wen, pc_wen, wb_sel}),
                32'h7);
        end
    endtask

    task automatic do_vec(input string name, input vec_t v);
        res_t r;
        logic pw, early;
        logic [31:0] iseen;
        run_inst(v.ins, v.d1, v.d2, v.d3, v.d4, r, pw, early, iseen);
        chk({name, "_lat"}, 32'(r.lat), 32'(v.exp.lat));
        chk({name, "_err"}, 32'(r.err), 32'(v.exp.err));
        chk({name, "_pc_wen"}, 32'(pw), 32'(!v.exp.err));
        chk({name, "_rf_wen"}, 32'(r.rf), 32'(v.exp.rf));
        chk({name, "_wb_sel"}, 32'(r.sel), 32'(v.exp.sel));
        chk({name, "_csr_wen"}, 32'(r.csr), 32'(v.exp.csr));
        chk({name, "_early_strobe"}, 32'(early), 32'd0);
        if (v.exp.lreq > 0) begin
            chk({name, "_lreq_cycles"}, 32'(r.lreq), 32'(v.exp.lreq));
            chk({name, "_lsu_we"}, 32'(r.we), 32'(v.exp.we));
        end
        if (v.exp.err) begin
            err_hold();
            do_reset();
        end else begin
            chk({name, "_inst"}, iseen, v.ins);
            idle_inputs();
            step();
            chk({name, "_next_fetch"}, 32'({ifu_req_valid, pc_wen, rf_wen}), 32'h4);
        end
    endtask

    function automatic vec_t mkv(input logic [31:0] ins, input int d1, d2, d3, d4,
                                 input logic rf, input logic [2:0] sel, input logic csr,
                                 input logic we, input int lreq, input int lat, input logic e);
        vec_t v;
        v.ins = ins; v.d1 = d1; v.d2 = d2; v.d3 = d3; v.d4 = d4;
        v.exp = '{rf: rf, sel: sel, csr: csr, we: we, lreq: lreq, lat: lat, err: e};
        return v;
    endfunction

    vec_t tbl[13];
    logic [6:0] ops[11];

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vec_t v;
        logic [31:0] r32;
        //              inst          d1 d2 d3 d4 rf sel    csr we lreq lat err
        tbl[0]  = mkv(32'h00500093, 0, 0, 0, 0, 1, 3'b010, 0, 0, 0,  4, 0); // addi
        tbl[1]  = mkv(32'h0000A103, 0, 0, 3, 2, 1, 3'b000, 0, 0, 4, 11, 0); // lw, slow LSU
        tbl[2]  = mkv(32'h0020A023, 0, 0, 0, 0, 0, 3'b111, 0, 1, 1,  6, 0); // sw
        tbl[3]  = mkv(32'h30529073, 0, 0, 0, 0, 1, 3'b100, 1, 0, 0,  4, 0); // csrrw
        tbl[4]  = mkv(32'h000000EF, 0, 0, 0, 0, 1, 3'b001, 0, 0, 0,  4, 0); // jal
        tbl[5]  = mkv(32'h123450B7, 0, 0, 0, 0, 1, 3'b011, 0, 0, 0,  4, 0); // lui
        tbl[6]  = mkv(32'h00208463, 0, 0, 0, 0, 0, 3'b111, 0, 0, 0,  4, 0); // beq
        tbl[7]  = mkv(32'h00500093, 7, 2, 0, 0, 1, 3'b010, 0, 0, 0, 13, 0); // ready on 8th FETCH cycle
        tbl[8]  = mkv(32'h000080E7, 1, 3, 0, 0, 1, 3'b001, 0, 0, 0,  8, 0); // jalr
        tbl[9]  = mkv(32'h0020A023, 0, 0, 7, 7, 0, 3'b111, 0, 1, 8, 20, 0); // sw, boundary waits
        tbl[10] = mkv(32'h0000007F, 0, 0, 0, 0, 0, 3'b111, 0, 0, 0,  4, 1); // illegal opcode
        tbl[11] = mkv(32'h00500093, 8, 0, 0, 0, 0, 3'b111, 0, 0, 0,  9, 1); // FETCH timeout
        tbl[12] = mkv(32'h0000A103, 0, 0, 0, 8, 0, 3'b111, 0, 0, 1, 13, 1); // MEM_WAIT timeout

        ops = '{7'b0000011, 7'b0100011, 7'b0010111, 7'b0010011, 7'b0110011, 7'b0110111,
                7'b1101111, 7'b1100111, 7'b1100011, 7'b1110011, 7'b0001111};

        do_reset();
        for (int i = 0; i < 13; i++) do_vec($sformatf("vec%0d", i), tbl[i]);

        // Reset pulsed while the LSU response is outstanding.
        ifu_req_ready = 1'b1;
        step();
        ifu_req_ready = 1'b0;
        chk("mr_rsp_ready", 32'(ifu_rsp_ready), 32'd1);
        ifu_rsp_valid = 1'b1;
        ifu_rdata     = 32'h0000A103;
        step();
        ifu_rsp_valid = 1'b0;
        step();
        chk("mr_mem_req", 32'({lsu_req_valid, lsu_we}), 32'h2);
        lsu_req_ready = 1'b1;
        step();
        lsu_req_ready = 1'b0;
        step();
        chk("mr_mem_wait", 32'({lsu_req_valid, ifu_req_valid, pc_wen}), 32'd0);
        #2 rst_n = 1'b0;
        #1;
        chk("mr_async_clear", 32'({ifu_req_valid, ifu_rsp_ready, lsu_req_valid, lsu_we, rf_wen, csr_wen, pc_wen, err}),
            32'd0);
        chk("mr_async_inst", inst, 32'd0);
        chk("mr_async_wb_sel", 32'(wb_sel), 32'd7);
        lsu_rsp_valid = 1'b1;
        step();
        chk("mr_hold_no_strobe", 32'({pc_wen, rf_wen, ifu_req_valid}), 32'd0);
        rst_n = 1'b1;
        step();
        lsu_rsp_valid = 1'b0;
        chk("mr_restart_fetch", 32'({ifu_req_valid, lsu_req_valid}), 32'h2);
        do_vec("mr_after", tbl[0]);

        // Random instructions and wait counts against the model.
        for (int n = 0; n < 40; n++) begin
            r32 = $urandom;
            r32[6:0] = ($urandom_range(0, 19) == 0) ? 7'b1111111 : ops[$urandom_range(0, 10)];
            v.ins = r32;
            v.d1 = ($urandom_range(0, 15) == 0) ? T : $urandom_range(0, 7);
            v.d2 = $urandom_range(0, 7);
            v.d3 = $urandom_range(0, 7);
            v.d4 = ($urandom_range(0, 15) == 0) ? T : $urandom_range(0, 7);
            v.exp = model(v.ins, v.d1, v.d2, v.d3, v.d4);
            do_vec($sformatf("rnd%0d", n), v);
        end

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
